// File: rtl/h264_invdc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : h264_invdc_pkg
// Description : Shared state encoding, accumulation width and result
//               narrowing for the inverse chroma DC transform.
//               Optional macro: H264_INVDC_SAT_EN (saturate instead of wrap).
// Revision    : 1.0 - initial release
// ============================================================================
package h264_invdc_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] S_IN   = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    // Four-term sums of DW-bit words need two guard bits.
    localparam int ACC_GUARD = 2;

    function automatic int acc_width(input int dw);
        return dw + ACC_GUARD;
    endfunction

    // Caller keeps the low dw bits of the result.
    function automatic logic signed [63:0] narrow(input logic signed [63:0] v,
                                                  input int dw);
`ifdef H264_INVDC_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
`else
        return v & ((64'sd1 <<< dw) - 64'sd1);
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/h264_invdc_butterfly.sv
`default_nettype none
// ============================================================================
// Module      : h264_invdc_butterfly
// Description : Combinational 2x2 inverse Hadamard butterfly at AW bits.
// Revision    : 1.0 - initial release
// ============================================================================
module h264_invdc_butterfly #(
    parameter int AW = 18
) (
    input  logic signed [AW-1:0] d00,
    input  logic signed [AW-1:0] d01,
    input  logic signed [AW-1:0] d10,
    input  logic signed [AW-1:0] d11,
    output logic signed [AW-1:0] f00,
    output logic signed [AW-1:0] f01,
    output logic signed [AW-1:0] f10,
    output logic signed [AW-1:0] f11
);

    logic signed [AW-1:0] s0;
    logic signed [AW-1:0] s1;
    logic signed [AW-1:0] t0;
    logic signed [AW-1:0] t1;

    always_comb begin
        s0  = d00 + d01;
        s1  = d10 + d11;
        t0  = d00 - d01;
        t1  = d10 - d11;
        f00 = s0 + s1;
        f01 = t0 + t1;
        f10 = s0 - s1;
        f11 = t0 - t1;
    end

endmodule
`default_nettype wire

// File: rtl/h264_invdc_transform.sv
`default_nettype none
// ============================================================================
// Module      : h264_invdc_transform
// Description : Streaming inverse 2x2 chroma DC Hadamard transform: collect
//               four words, one compute cycle, emit four words.
//               Optional macro: H264_INVDC_SAT_EN (saturate instead of wrap).
// Revision    : 1.0 - initial release
// ============================================================================
module h264_invdc_transform
    import h264_invdc_pkg::*;
#(
    parameter int TOGETHER = 0,
    parameter int DW       = 16
) (
    input  logic          CLK,
    input  logic          RESET,
    output logic          READYI,
    input  logic          ENABLE,
    input  logic [DW-1:0] XXIN,
    output logic          VALID,
    output logic [DW-1:0] YYOUT,
    input  logic          READYO
);

    localparam int AW = acc_width(DW);

    state_t        state_q, state_d;
    logic [1:0]    icnt_q, icnt_d;
    logic [1:0]    ocnt_q, ocnt_d;
    logic [DW-1:0] d_q [4];
    logic [DW-1:0] d_d [4];
    logic [DW-1:0] f_q [4];
    logic [DW-1:0] f_d [4];
    logic          valid_q, valid_d;
    logic [DW-1:0] yyout_q, yyout_d;

    logic signed [AW-1:0] w_ext [4];
    logic signed [AW-1:0] w_f   [4];
    logic                 w_emit;

    assign READYI = RESET && (state_q == S_IN);
    assign VALID  = valid_q;
    assign YYOUT  = yyout_q;

    always_comb begin
        for (int i = 0; i < 4; i++)
            w_ext[i] = {{(AW-DW){d_q[i][DW-1]}}, d_q[i]};
    end

    h264_invdc_butterfly #(
        .AW (AW)
    ) u_butterfly (
        .d00 (w_ext[0]),
        .d01 (w_ext[1]),
        .d10 (w_ext[2]),
        .d11 (w_ext[3]),
        .f00 (w_f[0]),
        .f01 (w_f[1]),
        .f10 (w_f[2]),
        .f11 (w_f[3])
    );

    // In burst mode only the first word waits for the sink.
    always_comb begin
        if (TOGETHER != 0)
            w_emit = READYO || (ocnt_q != 2'd0);
        else
            w_emit = READYO;
    end

    always_comb begin
        state_d = state_q;
        icnt_d  = icnt_q;
        ocnt_d  = ocnt_q;
        d_d     = d_q;
        f_d     = f_q;
        valid_d = 1'b0;
        yyout_d = yyout_q;
        case (state_q)
            S_IN: begin
                if (ENABLE && READYI) begin
                    d_d[icnt_q] = XXIN;
                    icnt_d      = icnt_q + 2'd1;
                    if (icnt_q == 2'd3)
                        state_d = S_CALC;
                end
            end
            S_CALC: begin
                for (int i = 0; i < 4; i++)
                    f_d[i] = DW'(narrow({{(64-AW){w_f[i][AW-1]}}, w_f[i]}, DW));
                state_d = S_OUT;
            end
            S_OUT: begin
                if (w_emit) begin
                    yyout_d = f_q[ocnt_q];
                    valid_d = 1'b1;
                    ocnt_d  = ocnt_q + 2'd1;
                    if (ocnt_q == 2'd3)
                        state_d = S_IN;
                end
            end
            default: state_d = S_IN;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IN;
            icnt_q  <= 2'd0;
            ocnt_q  <= 2'd0;
            valid_q <= 1'b0;
            yyout_q <= '0;
            for (int i = 0; i < 4; i++) begin
                d_q[i] <= '0;
                f_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
            ocnt_q  <= ocnt_d;
            valid_q <= valid_d;
            yyout_q <= yyout_d;
            d_q     <= d_d;
            f_q     <= f_d;
        end
    end

endmodule
`default_nettype wire
